// File: rtl/mem_arbiter.sv
// Purpose: two-client round-robin arbiter and enable/ready sequencer in front of the block RAM.
// Latency: grant edge to ack edge is memory DELAY+2 cycles; one idle RECOVER cycle follows every transaction.
// Backpressure: requests are level-held and wait while busy; a silent memory is aborted with err after TIMEOUT_CYCLES.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int MADDR_WIDTH    = 16,
  parameter int MDATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   c0_req,
  input  logic                   c0_we,
  input  logic [MADDR_WIDTH-1:0] c0_addr,
  input  logic [MDATA_WIDTH-1:0] c0_wdata,
  output logic                   c0_ack,
  output logic                   c0_err,

  input  logic                   c1_req,
  input  logic                   c1_we,
  input  logic [MADDR_WIDTH-1:0] c1_addr,
  input  logic [MDATA_WIDTH-1:0] c1_wdata,
  output logic                   c1_ack,
  output logic                   c1_err,

  output logic [MDATA_WIDTH-1:0] rdata,

  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  output logic [MDATA_WIDTH-1:0] mem_write_data,
  input  logic                   mem_read_ready,
  input  logic                   mem_write_ready,
  input  logic [MDATA_WIDTH-1:0] mem_read_data
);

  localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Registered state besides the FSM: owner of the current/last grant and the timeout counter.
  logic          last_grant;
  logic          last_grant_next;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_next;
  logic [CW-1:0] tcnt_inc;

  // Next values of the registered outputs.
  logic                   rd_en_next;
  logic                   wr_en_next;
  logic [MADDR_WIDTH-1:0] addr_next;
  logic [MDATA_WIDTH-1:0] wdata_next;
  logic [MDATA_WIDTH-1:0] rdata_next;
  logic                   c0_ack_next;
  logic                   c1_ack_next;
  logic                   c0_err_next;
  logic                   c1_err_next;

  // Arbitration and completion decode.
  logic                   any_req;
  logic                   grant_pick;
  logic                   sel_we;
  logic [MADDR_WIDTH-1:0] sel_addr;
  logic [MDATA_WIDTH-1:0] sel_wdata;
  logic                   op_ready;
  logic                   op_done;
  logic                   op_timeout;
  logic                   finish;

  assign any_req = c0_req | c1_req;

  // Round-robin pick: a lone requester wins, a tie goes to the client not granted last.
  always_comb begin
    grant_pick = 1'b0;
    if (c0_req && c1_req) begin
      grant_pick = ~last_grant;
    end else if (c1_req) begin
      grant_pick = 1'b1;
    end
  end

  assign sel_we    = grant_pick ? c1_we    : c0_we;
  assign sel_addr  = grant_pick ? c1_addr  : c0_addr;
  assign sel_wdata = grant_pick ? c1_wdata : c0_wdata;

  // Counter saturates at TMAX so a stuck FSM can never wrap back into a false window.
  assign tcnt_inc = (tcnt == TMAX) ? tcnt : tcnt + CW'(1);

  // Only the ready that matches the outstanding op counts; the other one is ignored.
  assign op_ready   = (mem_read_enable & mem_read_ready) | (mem_write_enable & mem_write_ready);
  assign op_done    = (state == ISSUE) && op_ready;
  assign op_timeout = (state == ISSUE) && !op_ready && (tcnt_inc == TMAX);
  assign finish     = op_done | op_timeout;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> ISSUE on any request, ISSUE -> RECOVER on ready or timeout, RECOVER -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   if (finish)  state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output and of the datapath registers.
  always_comb begin
    rd_en_next      = mem_read_enable;
    wr_en_next      = mem_write_enable;
    addr_next       = mem_addr;
    wdata_next      = mem_write_data;
    rdata_next      = rdata;
    c0_ack_next     = 1'b0;
    c1_ack_next     = 1'b0;
    c0_err_next     = 1'b0;
    c1_err_next     = 1'b0;
    tcnt_next       = tcnt;
    last_grant_next = last_grant;

    case (state)
      IDLE: begin
        rd_en_next = 1'b0;
        wr_en_next = 1'b0;
        if (any_req) begin
          last_grant_next = grant_pick;
          rd_en_next      = ~sel_we;
          wr_en_next      = sel_we;
          addr_next       = sel_addr;
          wdata_next      = sel_wdata;
          tcnt_next       = '0;
        end
      end

      ISSUE: begin
        tcnt_next = tcnt_inc;
        if (finish) begin
          rd_en_next  = 1'b0;
          wr_en_next  = 1'b0;
          c0_ack_next = ~last_grant;
          c1_ack_next = last_grant;
          c0_err_next = ~last_grant & op_timeout;
          c1_err_next = last_grant & op_timeout;
          // A timed-out read leaves the previous read data in place.
          if (op_done && mem_read_enable) begin
            rdata_next = mem_read_data;
          end
        end
      end

      RECOVER: begin
        // Enables stay low here so the memory's delay counter is cleared; echoed readies are ignored.
        rd_en_next = 1'b0;
        wr_en_next = 1'b0;
      end

      default: begin
        rd_en_next = 1'b0;
        wr_en_next = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset wins over a same-edge ready so no ack escapes.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      rdata            <= '0;
      c0_ack           <= 1'b0;
      c1_ack           <= 1'b0;
      c0_err           <= 1'b0;
      c1_err           <= 1'b0;
      tcnt             <= '0;
      last_grant       <= 1'b1;
    end else begin
      mem_read_enable  <= rd_en_next;
      mem_write_enable <= wr_en_next;
      mem_addr         <= addr_next;
      mem_write_data   <= wdata_next;
      rdata            <= rdata_next;
      c0_ack           <= c0_ack_next;
      c1_ack           <= c1_ack_next;
      c0_err           <= c0_err_next;
      c1_err           <= c1_err_next;
      tcnt             <= tcnt_next;
      last_grant       <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: drives both clients against a delayed block-RAM model with echoed ready pulses.
// Expected acks (client, err, rdata) are queued when a request is driven and popped when an ack appears.
// Timing, round-robin order, timeout, reset abort and enable stability are all checked.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TO    = 64;
  localparam int MEM_D = 10;
  localparam int LAT   = MEM_D + 2;

  logic          clock;
  logic          reset;
  logic          c0_req, c0_we, c0_ack, c0_err;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic          c1_req, c1_we, c1_ack, c1_err;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic [DW-1:0] rdata;
  logic          mem_read_enable, mem_write_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_ready, mem_write_ready;
  logic [DW-1:0] mem_read_data;

  typedef struct {
    logic          client;
    logic          err;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          v0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          first;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  int errors    = 0;
  int checks    = 0;
  int both_viol = 0;
  int stab_viol = 0;

  logic          p_rd, p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  mem_arbiter #(
    .MADDR_WIDTH   (AW),
    .MDATA_WIDTH   (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .c0_req          (c0_req),
    .c0_we           (c0_we),
    .c0_addr         (c0_addr),
    .c0_wdata        (c0_wdata),
    .c0_ack          (c0_ack),
    .c0_err          (c0_err),
    .c1_req          (c1_req),
    .c1_we           (c1_we),
    .c1_addr         (c1_addr),
    .c1_wdata        (c1_wdata),
    .c1_ack          (c1_ack),
    .c1_err          (c1_err),
    .rdata           (rdata),
    .mem_read_enable (mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_read_ready  (mem_read_ready),
    .mem_write_ready (mem_write_ready),
    .mem_read_data   (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: counts enabled cycles from 0, raises the matching ready after DELAY counts and
  // holds it while the enable stays high, so one echo pulse lands in the arbiter's RECOVER cycle.
  logic [DW-1:0] mem [0:255];
  int            mcnt;
  logic          mute;
  logic          mem_clr;
  logic [7:0]    midx;

  assign midx          = mem_addr[9:2];
  assign mem_read_data = mem[midx];

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16]         <= 32'hDEADBEEF;
      mcnt            <= 0;
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
    end else if (mem_read_enable || mem_write_enable) begin
      if (mcnt == MEM_D) begin
        if (!mute) begin
          mem_read_ready  <= mem_read_enable;
          mem_write_ready <= mem_write_enable;
          if (mem_write_enable) mem[midx] <= mem_write_data;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt            <= 0;
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // One cycle: wait for the falling edge, then run the protocol monitor and the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (mem_read_enable && mem_write_enable) both_viol++;
    if ((p_rd || p_wr) && (mem_read_enable || mem_write_enable)) begin
      if (p_rd != mem_read_enable || p_wr != mem_write_enable ||
          p_addr != mem_addr || p_wdata != mem_write_data) stab_viol++;
    end
    p_rd    = mem_read_enable;
    p_wr    = mem_write_enable;
    p_addr  = mem_addr;
    p_wdata = mem_write_data;
    if (c0_ack || c1_ack) begin
      check("ack_onehot", {63'd0, c0_ack & c1_ack}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got c0_ack=%b c1_ack=%b expected no ack", c0_ack, c1_ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_client", {63'd0, c1_ack}, {63'd0, e.client});
        check("ack_err", {63'd0, (c1_ack ? c1_err : c0_err)}, {63'd0, e.err});
        if (e.chk_rd) check("rdata", {32'd0, rdata}, {32'd0, e.rdata});
      end
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!c) begin
      c0_req = v; c0_we = we; c0_addr = a; c0_wdata = d;
    end else begin
      c1_req = v; c1_we = we; c1_addr = a; c1_wdata = d;
    end
  endtask

  task automatic push_exp(input logic c, input logic err, input logic chk_rd, input logic [DW-1:0] x);
    exp_t e;
    e.client = c;
    e.err    = err;
    e.chk_rd = chk_rd;
    e.rdata  = x;
    exp_q.push_back(e);
  endtask

  // Waits for client c's ack; grant-to-ack distance and enable-high cycles both equal lat_exp
  // because the enable rises on the grant edge and drops on the ack edge.
  task automatic await_ack(input logic c, input int lat_exp);
    int n = 0;
    int first = -1;
    int en_cnt = 0;
    bit done = 0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (mem_read_enable || mem_write_enable) begin
        en_cnt++;
        if (first < 0) first = n;
      end
      if (c ? c1_ack : c0_ack) begin
        done = 1;
        if (!c) c0_req = 1'b0; else c1_req = 1'b0;
        check("en_low_at_ack", {62'd0, mem_read_enable, mem_write_enable}, 64'd0);
        check("latency", 64'(n - first), 64'(lat_exp));
        check("en_cycles", 64'(en_cnt), 64'(lat_exp));
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: got no ack after %0d cycles expected ack from client %0d", n, c);
    end else begin
      tick();
      check("en_low_after_ack", {62'd0, mem_read_enable, mem_write_enable}, 64'd0);
    end
  endtask

  task automatic run_single(input logic c, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic chk_rd,
                            input logic [DW-1:0] x, input logic err, input int lat);
    push_exp(c, err, chk_rd, x);
    drive(c, 1'b1, we, a, d);
    await_ack(c, lat);
  endtask

  // Both clients (or one) raise req on the same edge; the queue order encodes the expected grant order.
  task automatic run_vec(input vec_t v);
    int n = 0;
    bit pend0, pend1;
    if (v.v0 && v.v1) begin
      if (!v.first) begin
        push_exp(1'b0, 1'b0, ~v.we0, v.x0);
        push_exp(1'b1, 1'b0, ~v.we1, v.x1);
      end else begin
        push_exp(1'b1, 1'b0, ~v.we1, v.x1);
        push_exp(1'b0, 1'b0, ~v.we0, v.x0);
      end
    end else if (v.v0) begin
      push_exp(1'b0, 1'b0, ~v.we0, v.x0);
    end else begin
      push_exp(1'b1, 1'b0, ~v.we1, v.x1);
    end
    pend0 = v.v0;
    pend1 = v.v1;
    if (v.v0) drive(1'b0, 1'b1, v.we0, v.a0, v.d0);
    if (v.v1) drive(1'b1, 1'b1, v.we1, v.a1, v.d1);
    while ((pend0 || pend1) && n < 400) begin
      tick();
      n++;
      if (c0_ack) begin c0_req = 1'b0; pend0 = 0; end
      if (c1_ack) begin c1_req = 1'b0; pend1 = 0; end
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("FAIL vec_wait: got pending c0=%b c1=%b expected both served", pend0, pend1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Expected data is derived from the writes earlier in the sequence; 'first' from last_grant history.
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 32'h0,        1'b1, 1'b0, 16'h0080, 32'h0,
                1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 32'hAAAA5555, 1'b0, 1'b0, 16'h0000, 32'h0,
                1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 32'h0,        1'b1, 1'b1, 16'h0104, 32'h0BADF00D,
                1'b1, 32'hAAAA5555, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 16'h0108, 32'h11112222, 1'b1, 1'b0, 16'h0104, 32'h0,
                1'b1, 32'h0,        32'h0BADF00D};
    vecs[4] = '{1'b1, 1'b0, 16'h0108, 32'h0,        1'b1, 1'b0, 16'h0040, 32'h0,
                1'b1, 32'h11112222, 32'hDEADBEEF};

    reset   = 1'b1;
    mem_clr = 1'b1;
    mute    = 1'b0;
    p_rd    = 1'b0;
    p_wr    = 1'b0;
    p_addr  = '0;
    p_wdata = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    // Reset values.
    check("rst_rd_en",  {63'd0, mem_read_enable},  64'd0);
    check("rst_wr_en",  {63'd0, mem_write_enable}, 64'd0);
    check("rst_addr",   {48'd0, mem_addr},         64'd0);
    check("rst_wdata",  {32'd0, mem_write_data},   64'd0);
    check("rst_rdata",  {32'd0, rdata},            64'd0);
    check("rst_acks",   {62'd0, c0_ack, c1_ack},   64'd0);
    check("rst_errs",   {62'd0, c0_err, c1_err},   64'd0);

    mem_clr = 1'b0;
    reset   = 1'b0;
    tick();

    // Single read, then write and read-back through the echoed-ready window.
    run_single(1'b0, 1'b0, 16'h0040, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, LAT);
    run_single(1'b1, 1'b1, 16'h0080, 32'h12345678, 1'b0, 32'h0,        1'b0, LAT);
    run_single(1'b1, 1'b0, 16'h0080, 32'h0,        1'b1, 32'h12345678, 1'b0, LAT);

    // Fresh reset so client 0 wins the first tie.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Silent memory: err after TO cycles of ISSUE, rdata keeps the last read, then normal service.
    mute = 1'b1;
    run_single(1'b1, 1'b0, 16'h0040, 32'h0, 1'b1, 32'h11112222, 1'b1, TO);
    mute = 1'b0;
    run_single(1'b1, 1'b0, 16'h0080, 32'h0, 1'b1, 32'h12345678, 1'b0, LAT);

    // Reset a few cycles into a write: no ack, enables drop, held req is re-granted with full latency.
    drive(1'b0, 1'b1, 1'b1, 16'h000C, 32'h55AA55AA);
    n = 0;
    while (!(mem_read_enable || mem_write_enable) && n < 50) begin
      tick();
      n++;
    end
    check("abort_granted", {63'd0, mem_write_enable}, 64'd1);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("abort_en",   {62'd0, mem_read_enable, mem_write_enable}, 64'd0);
    check("abort_ack",  {62'd0, c0_ack, c1_ack},                    64'd0);
    check("abort_addr", {48'd0, mem_addr},                          64'd0);
    reset = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 32'h0);
    await_ack(1'b0, LAT);
    run_single(1'b1, 1'b0, 16'h000C, 32'h0, 1'b1, 32'h55AA55AA, 1'b0, LAT);

    repeat (4) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("both_en_never",    64'(both_viol),    64'd0);
    check("issue_stable",     64'(stab_viol),    64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
